// File: rtl/rs_encode_stream_in_blocker_if.sv
// Request, input-line and output-line handshakes of the RS encoder stream-in blocker.
// slave = blocker side, master = surrounding environment side.
interface rs_encode_stream_in_blocker_if #(
   parameter int DATA_W         = 256,
   parameter int MAX_REQ_BLOCKS = 64
);
   localparam int MAX_REQ_BLOCKS_W = $clog2(MAX_REQ_BLOCKS);

   logic                      req_val;
   logic [MAX_REQ_BLOCKS_W:0] req_num_blocks;
   logic                      req_rdy;
   logic                      data_val;
   logic [DATA_W-1:0]         data;
   logic                      data_rdy;
   logic                      line_val;
   logic [DATA_W-1:0]         line_data;
   logic                      line_block_last;
   logic                      line_req_last;
   logic                      line_rdy;
   logic [MAX_REQ_BLOCKS_W:0] req_num_blocks_q;
   logic                      busy;

   modport slave (
      input  req_val, req_num_blocks, data_val, data, line_rdy,
      output req_rdy, data_rdy, line_val, line_data, line_block_last, line_req_last,
             req_num_blocks_q, busy
   );

   modport master (
      output req_val, req_num_blocks, data_val, data, line_rdy,
      input  req_rdy, data_rdy, line_val, line_data, line_block_last, line_req_last,
             req_num_blocks_q, busy
   );
endinterface

// File: rtl/rs_encode_stream_in_blocker.sv
// Stream-in blocker: slices input lines into RS data blocks, masks the tail, appends zero pad lines.
// Optional statistics counters are enabled by defining RS_STREAM_IN_STATS_EN.
module rs_encode_stream_in_blocker #(
   parameter int DATA_W         = 256,
   parameter int RS_DATA_BYTES  = 223,
   parameter int NUM_PAD_LINES  = 1,
   parameter int MAX_REQ_BLOCKS = 64
) (
   input  logic clk,
   input  logic rst,
   rs_encode_stream_in_blocker_if.slave bus
`ifdef RS_STREAM_IN_STATS_EN
   ,
   output logic [31:0] stat_lines_in,
   output logic [31:0] stat_reqs_done
`endif
);

   localparam int DATA_BYTES     = DATA_W / 8;
   localparam int NUM_DATA_LINES = (RS_DATA_BYTES + DATA_BYTES - 1) / DATA_BYTES;
   localparam int TOTAL_LINES    = NUM_DATA_LINES + NUM_PAD_LINES;
   localparam int LC_W           = (TOTAL_LINES > 1) ? $clog2(TOTAL_LINES) : 1;
   localparam int BLK_W          = $clog2(MAX_REQ_BLOCKS) + 1;
   localparam int LAST_BYTES     = RS_DATA_BYTES - (NUM_DATA_LINES - 1) * DATA_BYTES;

   localparam logic [LC_W-1:0] LAST_DATA_IDX = LC_W'(NUM_DATA_LINES - 1);
   localparam logic [LC_W-1:0] LAST_LINE_IDX = LC_W'(TOTAL_LINES - 1);

   // Byte 0 sits in the MSBs; bytes past the end of the RS block are forced to zero.
   function automatic logic [DATA_W-1:0] tail_mask_f();
      logic [DATA_W-1:0] m;
      m = '0;
      for (int i = 0; i < DATA_BYTES; i++) begin
         if (i < LAST_BYTES) m[DATA_W-1-8*i -: 8] = 8'hFF;
      end
      return m;
   endfunction

   localparam logic [DATA_W-1:0] TAIL_MASK = tail_mask_f();

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DATA = 2'd1,
      S_PAD  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [LC_W-1:0]   line_cnt_q, line_cnt_d;
   logic [BLK_W-1:0]  blk_cnt_q, blk_cnt_d;
   logic [BLK_W-1:0]  num_q, num_d;

   logic              req_rdy_c, data_rdy_c, line_val_c;
   logic [DATA_W-1:0] line_data_c;
   logic              block_last_c, req_last_c;
   logic              line_hs, data_hs, zero_req;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
      state_d      = state_q;
      line_cnt_d   = line_cnt_q;
      blk_cnt_d    = blk_cnt_q;
      num_d        = num_q;
      req_rdy_c    = 1'b0;
      data_rdy_c   = 1'b0;
      line_val_c   = 1'b0;
      line_data_c  = '0;
      block_last_c = 1'b0;
      req_last_c   = 1'b0;
      line_hs      = 1'b0;
      data_hs      = 1'b0;
      zero_req     = 1'b0;

      case (state_q)
         S_IDLE: begin
            req_rdy_c = 1'b1;
            if (bus.req_val) begin
               num_d      = bus.req_num_blocks;
               line_cnt_d = '0;
               blk_cnt_d  = '0;
               if (bus.req_num_blocks != '0) state_d = S_DATA;
               else                          zero_req = 1'b1;
            end
         end
         S_DATA: begin
            line_val_c   = bus.data_val;
            data_rdy_c   = bus.line_rdy;
            line_data_c  = (line_cnt_q == LAST_DATA_IDX) ? (bus.data & TAIL_MASK) : bus.data;
            block_last_c = (line_cnt_q == LAST_LINE_IDX);
            line_hs      = bus.data_val && bus.line_rdy;
            data_hs      = line_hs;
         end
         S_PAD: begin
            line_val_c   = 1'b1;
            block_last_c = (line_cnt_q == LAST_LINE_IDX);
            line_hs      = bus.line_rdy;
         end
         default: state_d = S_IDLE;
      endcase

      req_last_c = block_last_c && (blk_cnt_q == num_q - BLK_W'(1));

      // With no pad lines the last data index is also the block-last index, so that branch wins.
      if (line_hs) begin
         if (block_last_c) begin
            line_cnt_d = '0;
            if (req_last_c) begin
               state_d = S_IDLE;
            end else begin
               blk_cnt_d = blk_cnt_q + BLK_W'(1);
               state_d   = S_DATA;
            end
         end else begin
            line_cnt_d = line_cnt_q + LC_W'(1);
            if (state_q == S_DATA && line_cnt_q == LAST_DATA_IDX) state_d = S_PAD;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         line_cnt_q <= '0;
         blk_cnt_q  <= '0;
         num_q      <= '0;
      end else begin
         state_q    <= state_d;
         line_cnt_q <= line_cnt_d;
         blk_cnt_q  <= blk_cnt_d;
         num_q      <= num_d;
      end
   end

   // Outputs read as zero for the whole time rst is held, not just after the first edge.
   assign bus.req_rdy          = !rst && req_rdy_c;
   assign bus.data_rdy         = !rst && data_rdy_c;
   assign bus.line_val         = !rst && line_val_c;
   assign bus.line_data        = rst ? '0 : line_data_c;
   assign bus.line_block_last  = !rst && block_last_c;
   assign bus.line_req_last    = !rst && req_last_c;
   assign bus.req_num_blocks_q = rst ? '0 : num_q;
   assign bus.busy             = !rst && (state_q != S_IDLE);

`ifdef RS_STREAM_IN_STATS_EN
   logic [31:0] stat_lines_q, stat_reqs_q;

   // Zero-block requests complete instantly, so they count as finished requests too.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_lines_q <= '0;
         stat_reqs_q  <= '0;
      end else begin
         if (data_hs) stat_lines_q <= stat_lines_q + 32'd1;
         if ((line_hs && req_last_c) || zero_req) stat_reqs_q <= stat_reqs_q + 32'd1;
      end
   end

   assign stat_lines_in  = stat_lines_q;
   assign stat_reqs_done = stat_reqs_q;
`endif

endmodule

// File: tb/tb_rs_encode_stream_in_blocker.sv
// Directed bench for rs_encode_stream_in_blocker: DATA_W=64, RS_DATA_BYTES=20, one pad line.
// Define RS_STREAM_IN_STATS_EN to include the statistics counter test.
module tb_rs_encode_stream_in_blocker;
   localparam int DATA_W = 64;
   localparam int NB_W   = $clog2(64) + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   rs_encode_stream_in_blocker_if #(.DATA_W(DATA_W), .MAX_REQ_BLOCKS(64)) bus ();

`ifdef RS_STREAM_IN_STATS_EN
   logic [31:0] stat_lines_in, stat_reqs_done;
`endif

   rs_encode_stream_in_blocker #(
      .DATA_W(DATA_W), .RS_DATA_BYTES(20), .NUM_PAD_LINES(1), .MAX_REQ_BLOCKS(64)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
`ifdef RS_STREAM_IN_STATS_EN
      ,
      .stat_lines_in(stat_lines_in),
      .stat_reqs_done(stat_reqs_done)
`endif
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] in_line(input int j);
      case (j % 3)
         0:       return 64'h1111_1111_1111_1111;
         1:       return 64'h2222_2222_2222_2222;
         default: return 64'h3333_3333_3333_3333;
      endcase
   endfunction

   // Line 2 keeps 20-16=4 bytes; line 3 is the pad line.
   function automatic logic [63:0] exp_line(input int k);
      case (k)
         0:       return 64'h1111_1111_1111_1111;
         1:       return 64'h2222_2222_2222_2222;
         2:       return 64'h3333_3333_0000_0000;
         default: return 64'h0;
      endcase
   endfunction

   // mode 0: line_rdy always 1; mode 1: line_rdy pattern 1,0,0 repeating.
   // stop_in > 0 returns (at a negedge) once that many data lines were consumed.
   task automatic run_req(input int n, input int mode, input int stop_in);
      int in_idx  = 0;
      int out_idx = 0;
      int cyc     = 0;
      int total   = n * 4;
      int k, b;
      @(negedge clk);
      bus.req_val        = 1'b1;
      bus.req_num_blocks = NB_W'(n);
      bus.data_val       = 1'b0;
      bus.line_rdy       = 1'b1;
      #1;
      check("req_rdy_idle", 64'(bus.req_rdy), 64'd1);
      @(negedge clk);
      bus.req_val = 1'b0;
      while (out_idx < total && cyc < 200) begin
         if (stop_in > 0 && in_idx == stop_in) return;
         bus.line_rdy = (mode == 0) || (cyc % 3 == 0);
         bus.data_val = 1'b1;
         bus.data     = in_line(in_idx);
         #1;
         k = out_idx % 4;
         b = out_idx / 4;
         check("busy", 64'(bus.busy), 64'd1);
         check("req_rdy_busy", 64'(bus.req_rdy), 64'd0);
         check("num_blocks_q", 64'(bus.req_num_blocks_q), 64'(n));
         check("line_val", 64'(bus.line_val), 64'd1);
         check("data_rdy", 64'(bus.data_rdy), 64'(bus.line_rdy && k < 3));
         check("line_data", bus.line_data, exp_line(k));
         check("block_last", 64'(bus.line_block_last), 64'(k == 3));
         check("req_last", 64'(bus.line_req_last), 64'(k == 3 && b == n - 1));
         if (bus.line_val && bus.line_rdy) out_idx++;
         if (bus.data_val && bus.data_rdy) in_idx++;
         cyc++;
         @(negedge clk);
      end
      check("lines_out", 64'(out_idx), 64'(total));
      check("lines_in", 64'(in_idx), 64'(3 * n));
      bus.data_val = 1'b0;
      #1;
      check("busy_after", 64'(bus.busy), 64'd0);
      check("req_rdy_after", 64'(bus.req_rdy), 64'd1);
      check("line_val_after", 64'(bus.line_val), 64'd0);
   endtask

   task automatic run_zero_req();
      @(negedge clk);
      bus.req_val        = 1'b1;
      bus.req_num_blocks = '0;
      bus.data_val       = 1'b1;
      bus.line_rdy       = 1'b1;
      #1;
      check("zero_req_rdy", 64'(bus.req_rdy), 64'd1);
      @(negedge clk);
      bus.req_val = 1'b0;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("zero_busy", 64'(bus.busy), 64'd0);
         check("zero_line_val", 64'(bus.line_val), 64'd0);
         check("zero_req_rdy_hold", 64'(bus.req_rdy), 64'd1);
         check("zero_num_q", 64'(bus.req_num_blocks_q), 64'd0);
         @(negedge clk);
      end
      bus.data_val = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_val        = 1'b1;
      bus.req_num_blocks = NB_W'(5);
      bus.data_val       = 1'b1;
      bus.data           = '1;
      bus.line_rdy       = 1'b1;
      rst                = 1'b1;

      repeat (2) @(negedge clk);
      #1;
      check("rst_req_rdy", 64'(bus.req_rdy), 64'd0);
      check("rst_data_rdy", 64'(bus.data_rdy), 64'd0);
      check("rst_line_val", 64'(bus.line_val), 64'd0);
      check("rst_line_data", bus.line_data, 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_num_q", 64'(bus.req_num_blocks_q), 64'd0);
      check("rst_flags", 64'({bus.line_block_last, bus.line_req_last}), 64'd0);

      @(negedge clk);
      bus.req_val  = 1'b0;
      bus.data_val = 1'b0;
      rst          = 1'b0;
      @(negedge clk);
      #1;
      check("idle_req_rdy", 64'(bus.req_rdy), 64'd1);
      check("idle_busy", 64'(bus.busy), 64'd0);
      check("idle_num_q", 64'(bus.req_num_blocks_q), 64'd0);

      run_req(1, 0, 0);   // T1 basic
      run_req(3, 0, 0);   // T2 multi-block
      run_req(1, 1, 0);   // T3 backpressure
      run_zero_req();     // T4 zero blocks

      // T5: reset after the second data line of a two-block request
      run_req(2, 0, 2);
      rst = 1'b1;
      @(negedge clk);
      rst          = 1'b0;
      bus.data_val = 1'b1;
      #1;
      check("mid_rst_line_val", 64'(bus.line_val), 64'd0);
      check("mid_rst_busy", 64'(bus.busy), 64'd0);
      check("mid_rst_req_rdy", 64'(bus.req_rdy), 64'd1);
      bus.data_val = 1'b0;
      run_req(1, 0, 0);

`ifdef RS_STREAM_IN_STATS_EN
      // T6: counters from a clean reset across a 3-block and a zero-block request
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      run_req(3, 0, 0);
      run_zero_req();
      #1;
      check("stat_lines_in", 64'(stat_lines_in), 64'd9);
      check("stat_reqs_done", 64'(stat_reqs_done), 64'd2);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
